seq_magnitude_comparator: RTL and testbench
===========================================

Name: seq_magnitude_comparator

Overview:
- Parametrised, multi-cycle successor to the team's 4-bit combinational magnitude comparator.
- Compares two WIDTH-bit operands DIGIT bits per cycle, starting at the most-significant digit, and terminates early at the first differing digit.
- Supports unsigned and two's-complement signed modes, with a start/busy/done handshake.
- Sits in the datapath wherever wide compares must not sit on a single-cycle critical path.

Parameters:
- WIDTH, 16, operand width in bits. Must be a multiple of DIGIT.
- DIGIT, 4, bits compared per cycle. Must satisfy 1 <= DIGIT <= WIDTH.
- N (localparam), WIDTH/DIGIT, number of digits.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a compare. Sampled only in IDLE.
- signed_mode  input  1  1 = two's-complement compare, 0 = unsigned. Sampled with start.
- A  input  WIDTH  operand A. Sampled with start.
- B  input  WIDTH  operand B. Sampled with start.
- busy  output  1  high while a compare is in progress (COMPARE state).
- done  output  1  one-cycle pulse when a new result is valid.
- AGreaterB  output  1  registered result: A > B.
- ALesserB  output  1  registered result: A < B.
- AEqualB  output  1  registered result: A == B.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - busy, done, AGreaterB, ALesserB and AEqualB all go to 0.
  - Digit index is cleared.
- States: IDLE, COMPARE.
- IDLE:
  - On the rising edge with start=1, register A and B into internal shift registers.
  - If signed_mode=1, invert bit WIDTH-1 of both registered copies. This offset-binary mapping makes the unsigned digit compare yield the signed ordering.
  - Set digit index to N-1, go to COMPARE, set busy=1.
- COMPARE:
  - Each edge examines digit [idx*DIGIT +: DIGIT] of both operands.
  - Digits differ: update the result flags from that digit (greater or lesser), assert done=1, set busy=0, go to IDLE.
  - Digits equal and idx==0: set AEqualB=1 and clear the others, assert done=1, set busy=0, go to IDLE.
  - Otherwise: idx decrements, state stays COMPARE.
- Latency:
  - done rises k edges after the start-accept edge, with k = (N - index of the most-significant differing digit).
  - k = N when the operands are equal, so latency ranges from 1 to N.
- Result flags:
  - Exactly one flag is high after the first done.
  - All flags are 0 before any compare completes.
  - Flags are updated only on the done edge and hold until the next done.
- done is a single-cycle pulse. It is 0 in every cycle except the one following the result edge.
- Start rules:
  - start while busy=1 is ignored. It is not queued, and the operands in flight are unaffected.
  - start asserted in the cycle where done=1 is accepted, because the state is already IDLE. This gives back-to-back compares with no dead cycle.
- Input changes: changes to A, B or signed_mode during COMPARE have no effect.
- Reset mid-compare: the compare aborts immediately, no done pulse is produced, and all flags are cleared.
- DIGIT=WIDTH (N=1): every compare completes in 1 cycle.

Test Plan (WIDTH=16, DIGIT=4):
1. start with A=16'h1234, B=16'h1234, signed_mode=0 -> busy high for 4 cycles, done pulses 4 edges after accept, AEqualB=1, the other flags 0.
2. A=16'h8000, B=16'h7FFF, signed_mode=0 -> done after 1 edge, AGreaterB=1. Repeat with signed_mode=1 -> done after 1 edge, ALesserB=1.
3. A=16'h12A0, B=16'h1290, unsigned -> digit 1 differs, done after 3 edges, AGreaterB=1. Then A=16'hFFFF (-1), B=16'h0001, signed -> ALesserB=1 after 1 edge.
4. Start A=16'h0000, B=16'h0000, then pulse start with A=16'hFFFF, B=16'h0000 two cycles later while busy -> that start is ignored, result AEqualB=1 at 4 edges. Then assert start during the done cycle with A=16'h0001, B=16'h0002 -> accepted, ALesserB=1 after 4 edges.
5. Start A=16'h5555, B=16'h5555 and drop rst_n after 2 cycles -> outputs go to 0 immediately, no done pulse. After release, a fresh compare works normally.
6. Rerun scenario 1 and scenario 2 (unsigned) with DIGIT=16 -> done after 1 edge with the same flag results.

Source files
------------

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle magnitude comparator.
// Walks both operands one DIGIT-wide slice per cycle from the most-significant
// end and stops at the first slice that differs. Signed mode flips the sign
// bit of both operands on load (offset binary), so the same unsigned slice
// compare gives the two's-complement ordering.
module seq_magnitude_comparator #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             AGreaterB,
    output logic             ALesserB,
    output logic             AEqualB
);

    localparam int N     = WIDTH / DIGIT;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic {
        IDLE,
        COMPARE
    } state_t;

    state_t           state, stateNext;
    logic [IDX_W-1:0] digitIdx, digitIdxNext;
    logic             busyNext, doneNext;
    logic             greaterNext, lesserNext, equalNext;
    logic             loadOps, shiftOps;

    // Operand copies; the digit under test is always the top DIGIT bits.
    logic [WIDTH-1:0] shiftA, shiftB;
    logic [WIDTH-1:0] mappedA, mappedB;
    logic [DIGIT-1:0] digA, digB;

    assign digA = shiftA[WIDTH-1 -: DIGIT];
    assign digB = shiftB[WIDTH-1 -: DIGIT];

    // Offset-binary mapping of the incoming operands when signed_mode is set.
    always_comb begin
        mappedA            = A;
        mappedB            = B;
        mappedA[WIDTH-1]   = A[WIDTH-1] ^ signed_mode;
        mappedB[WIDTH-1]   = B[WIDTH-1] ^ signed_mode;
    end

    // Next-state, handshake and result-flag decisions.
    always_comb begin
        stateNext    = state;
        digitIdxNext = digitIdx;
        busyNext     = 1'b0;
        doneNext     = 1'b0;
        greaterNext  = AGreaterB;
        lesserNext   = ALesserB;
        equalNext    = AEqualB;
        loadOps      = 1'b0;
        shiftOps     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    loadOps      = 1'b1;
                    digitIdxNext = LAST_IDX;
                    busyNext     = 1'b1;
                    stateNext    = COMPARE;
                end
            end
            COMPARE: begin
                busyNext = 1'b1;
                if (digA != digB) begin
                    greaterNext = (digA > digB);
                    lesserNext  = (digA < digB);
                    equalNext   = 1'b0;
                    doneNext    = 1'b1;
                    busyNext    = 1'b0;
                    stateNext   = IDLE;
                end else if (digitIdx == '0) begin
                    greaterNext = 1'b0;
                    lesserNext  = 1'b0;
                    equalNext   = 1'b1;
                    doneNext    = 1'b1;
                    busyNext    = 1'b0;
                    stateNext   = IDLE;
                end else begin
                    digitIdxNext = digitIdx - 1'b1;
                    shiftOps     = 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Control and result registers; reset aborts any compare in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            digitIdx  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            AGreaterB <= 1'b0;
            ALesserB  <= 1'b0;
            AEqualB   <= 1'b0;
        end else begin
            state     <= stateNext;
            digitIdx  <= digitIdxNext;
            busy      <= busyNext;
            done      <= doneNext;
            AGreaterB <= greaterNext;
            ALesserB  <= lesserNext;
            AEqualB   <= equalNext;
        end
    end

    // Operand shift registers: load on accept, move the next digit up on a tie.
    always_ff @(posedge clk) begin
        if (loadOps) begin
            shiftA <= mappedA;
            shiftB <= mappedB;
        end else if (shiftOps) begin
            shiftA <= shiftA << DIGIT;
            shiftB <= shiftB << DIGIT;
        end
    end

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Scoreboard bench for seq_magnitude_comparator: one DIGIT=4 instance and one
// DIGIT=16 instance, expected results from a plain-arithmetic model.
module tb_seq_magnitude_comparator;

    typedef struct {
        logic [2:0] flags;   // {AGreaterB, ALesserB, AEqualB}
        int         doneCyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start4 = 1'b0, start16 = 1'b0;
    logic        signedMode = 1'b0;
    logic [15:0] opA = '0, opB = '0;
    logic        busy4, done4, gt4, lt4, eq4;
    logic        busy16, done16, gt16, lt16, eq16;

    int   cyc = 0;
    int   nVec = 0;
    int   nFail = 0;
    exp_t q0[$];
    exp_t q1[$];
    logic [2:0] lastFlags0 = '0, lastFlags1 = '0;

    seq_magnitude_comparator #(.WIDTH(16), .DIGIT(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .signed_mode(signedMode),
        .A(opA), .B(opB), .busy(busy4), .done(done4),
        .AGreaterB(gt4), .ALesserB(lt4), .AEqualB(eq4)
    );

    seq_magnitude_comparator #(.WIDTH(16), .DIGIT(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .signed_mode(signedMode),
        .A(opA), .B(opB), .busy(busy16), .done(done16),
        .AGreaterB(gt16), .ALesserB(lt16), .AEqualB(eq16)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        nVec++;
        if (act != exp) begin
            nFail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: ordering from plain (signed) arithmetic; latency from the
    // position of the most-significant differing digit.
    function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                  input bit sm, input int digit,
                                  output logic [2:0] f, output int k);
        int  n    = 16 / digit;
        int  mask = (1 << digit) - 1;
        int  ai   = int'(a);
        int  bi   = int'(b);
        bit  gt, lt, found;
        if (sm) begin
            gt = $signed(a) > $signed(b);
            lt = $signed(a) < $signed(b);
        end else begin
            gt = a > b;
            lt = a < b;
        end
        f     = {gt, lt, !(gt || lt)};
        k     = n;
        found = 1'b0;
        for (int i = n - 1; i >= 0; i--) begin
            if (!found && (((ai >> (i * digit)) & mask) != ((bi >> (i * digit)) & mask))) begin
                k     = n - i;
                found = 1'b1;
            end
        end
    endfunction

    function automatic logic busyOf(input int inst);
        return (inst == 0) ? busy4 : busy16;
    endfunction

    // Called at posedge+#1; raises start for the next edge and scrambles the
    // operand inputs afterwards, which must not disturb the compare in flight.
    task automatic driveStart(input int inst, input logic [15:0] a, input logic [15:0] b,
                              input bit sm, input bit expAccept);
        exp_t       e;
        logic [2:0] f;
        int         k;
        opA        = a;
        opB        = b;
        signedMode = sm;
        if (inst == 0) start4 = 1'b1;
        else           start16 = 1'b1;
        if (expAccept) begin
            model(a, b, sm, (inst == 0) ? 4 : 16, f, k);
            e.flags   = f;
            e.doneCyc = cyc + 1 + k;
            if (inst == 0) q0.push_back(e);
            else           q1.push_back(e);
        end
        @(posedge clk);
        #1;
        start4     = 1'b0;
        start16    = 1'b0;
        opA        = 16'($urandom);
        opB        = 16'($urandom);
        signedMode = 1'($urandom);
    endtask

    task automatic waitIdle(input int inst);
        int n = 0;
        while (busyOf(inst) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 200) chk("waitIdle timeout", 1, 0);
    endtask

    task automatic stepCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: pop on every done, check flags and timing; otherwise flags hold.
    always @(negedge clk) begin
        if (rst_n) begin
            exp_t e;
            if (done4) begin
                if (q0.size() == 0) chk("d4 unexpected done", 1, 0);
                else begin
                    e = q0.pop_front();
                    chk("d4 flags", int'({gt4, lt4, eq4}), int'(e.flags));
                    chk("d4 done cycle", cyc, e.doneCyc);
                end
                lastFlags0 = {gt4, lt4, eq4};
            end else begin
                chk("d4 flags hold", int'({gt4, lt4, eq4}), int'(lastFlags0));
            end
            if (done16) begin
                if (q1.size() == 0) chk("d16 unexpected done", 1, 0);
                else begin
                    e = q1.pop_front();
                    chk("d16 flags", int'({gt16, lt16, eq16}), int'(e.flags));
                    chk("d16 done cycle", cyc, e.doneCyc);
                end
                lastFlags1 = {gt16, lt16, eq16};
            end else begin
                chk("d16 flags hold", int'({gt16, lt16, eq16}), int'(lastFlags1));
            end
        end
    end

    initial begin
        logic [15:0] a, b;
        int          inst, mode, pos;
        bit          sm;

        // Reset state
        #12;
        chk("reset busy4", busy4, 0);
        chk("reset done4", done4, 0);
        chk("reset flags4", int'({gt4, lt4, eq4}), 0);
        chk("reset busy16", busy16, 0);
        chk("reset flags16", int'({gt16, lt16, eq16}), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        stepCycles(2);

        // 1: equal operands, full-length compare, busy for 4 cycles
        driveStart(0, 16'h1234, 16'h1234, 0, 1);
        for (int i = 0; i < 4; i++) begin
            chk("t1 busy high", busy4, 1);
            @(posedge clk);
            #1;
        end
        chk("t1 busy low at done", busy4, 0);
        chk("t1 done", done4, 1);
        stepCycles(1);
        chk("t1 done single pulse", done4, 0);

        // 2: MSB decides; unsigned then signed
        driveStart(0, 16'h8000, 16'h7FFF, 0, 1);
        waitIdle(0);
        driveStart(0, 16'h8000, 16'h7FFF, 1, 1);
        waitIdle(0);

        // 3: digit 1 differs; signed -1 vs 1
        driveStart(0, 16'h12A0, 16'h1290, 0, 1);
        waitIdle(0);
        driveStart(0, 16'hFFFF, 16'h0001, 1, 1);
        waitIdle(0);
        stepCycles(1);

        // 4: start while busy is ignored; start in the done cycle is accepted
        driveStart(0, 16'h0000, 16'h0000, 0, 1);
        stepCycles(1);
        driveStart(0, 16'hFFFF, 16'h0000, 0, 0);
        waitIdle(0);
        chk("t4 done cycle seen", done4, 1);
        driveStart(0, 16'h0001, 16'h0002, 0, 1);
        waitIdle(0);
        stepCycles(1);

        // 5: reset mid-compare
        driveStart(0, 16'h5555, 16'h5555, 0, 1);
        stepCycles(1);
        rst_n = 1'b0;
        q0.delete();
        lastFlags0 = '0;
        lastFlags1 = '0;
        #1;
        chk("t5 busy cleared", busy4, 0);
        chk("t5 done cleared", done4, 0);
        chk("t5 flags cleared", int'({gt4, lt4, eq4}), 0);
        stepCycles(2);
        rst_n = 1'b1;
        stepCycles(5);
        driveStart(0, 16'h0F00, 16'h0E00, 0, 1);
        waitIdle(0);
        stepCycles(1);

        // 6: DIGIT=16 instance, single-cycle compares
        driveStart(1, 16'h1234, 16'h1234, 0, 1);
        waitIdle(1);
        driveStart(1, 16'h8000, 16'h7FFF, 0, 1);
        waitIdle(1);
        driveStart(1, 16'h8000, 16'h7FFF, 1, 1);
        waitIdle(1);

        // Randomised compares on both instances
        for (int it = 0; it < 300; it++) begin
            inst = int'($urandom_range(0, 1));
            mode = int'($urandom_range(0, 3));
            a    = 16'($urandom);
            sm   = 1'($urandom);
            case (mode)
                0: b = 16'($urandom);
                1: b = a;
                2: begin
                    pos = int'($urandom_range(0, 3));
                    b   = a ^ (16'(int'($urandom_range(1, 15))) << (4 * pos));
                end
                default: b = a ^ (16'h1 << $urandom_range(0, 15));
            endcase
            waitIdle(inst);
            driveStart(inst, a, b, sm, 1);
            if ($urandom_range(0, 3) == 0 && busyOf(inst))
                driveStart(inst, 16'($urandom), 16'($urandom), 1'($urandom), 0);
            if ($urandom_range(0, 4) == 0) stepCycles(1);
        end

        waitIdle(0);
        waitIdle(1);
        stepCycles(3);
        chk("scoreboard d4 drained", q0.size(), 0);
        chk("scoreboard d16 drained", q1.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

endmodule
